of_stage: RTL and testbench
===========================

Name: of_stage

Overview:
- Operand Fetch stage of the 5-stage in-order 32-bit RISC pipeline, directly downstream of the IF stage.
- Consumes the IF/OF payload (PC, instruction, valid), decodes it and reads the 16x32 register file, which is owned by this block and written by WB.
- Builds immediates and branch targets and detects load-use hazards.
- Registers a decoded OF/EX payload, with flush and stall control.

Parameters:
DATA_WIDTH, 32, datapath/register width
NUM_REGS, 16, architectural registers (r15 = return address)
REG_ADDR_WIDTH, 4, register index width

Ports:
Clk  in  1  clock, all state on rising edge
Rst  in  1  reset, synchronous and active-high
If_Valid  in  1  IF payload valid
If_Pc  in  32  PC of fetched instruction
If_Instr  in  32  fetched instruction
Of_Stall  out  1  hold IF (PC and IF/OF register) this cycle
Ex_IsBranchTaken  in  1  flush: discard instruction in OF
Wb_WrEn  in  1  register file write enable
Wb_Rd  in  4  write index
Wb_Data  in  32  write data
Of_Valid  out  1  OF/EX payload valid
Of_Pc  out  32  PC
Of_Opcode  out  5  instr[31:27]
Of_Op1  out  32  rs1 value (r15 for ret)
Of_Op2  out  32  immediate if I=1, else rs2 value
Of_StoreData  out  32  rd value (for st)
Of_Rd  out  4  destination (15 for call)
Of_WrEn  out  1  instruction writes a register
Of_IsLoad  out  1  ld
Of_IsStore  out  1  st
Of_IsBranch  out  1  beq/bgt/b/call/ret
Of_BranchTarget  out  32  If_Pc + (sign-extended instr[26:0] << 2), wrapping mod 2^32

Behaviour:
- Instruction fields: opcode[31:27], I[26], rd[25:22], rs1[21:18], rs2[17:14], modifier[17:16], imm[15:0].
- Opcode encodings: add 0, sub 1, mul 2, div 3, mod 4, cmp 5, and 6, or 7, not 8, mov 9, lsl 10, lsr 11, asr 12, nop 13, ld 14, st 15, beq 16, bgt 17, b 18, call 19, ret 20. Opcodes 21-31 decode as nop: WrEn=0, no flags.
- Immediate by modifier:
  - 00: sign-extend imm.
  - 01: zero-extend imm.
  - 10: imm<<16.
  - 11: treated as 00.
- Read port A address = (ret ? 15 : rs1). Read port B address = (st ? rd : rs2). Of_StoreData comes from port B.
- Of_WrEn=1 for opcodes 0-4, 6-12, 14 and 19. Opcode 19 forces Of_Rd=15. For all other opcodes Of_Rd = rd.
- Register file: 16x32, all zero after Rst. Write on rising edge when Wb_WrEn. r0 is an ordinary register.
- Latency: 1 cycle. An instruction accepted at edge N appears on Of_* after edge N.
- Load-use hazard (combinational):
  - Condition: Of_Valid & Of_IsLoad & If_Valid & the incoming instruction reads Of_Rd.
  - An instruction "reads" a register when the register is used as a source: rs1 for non-mov/non-b/non-call, rs2 when I=0 for ALU ops and cmp, rd for st, r15 for ret.
  - On hazard: Of_Stall=1 and a bubble is inserted (Of_Valid<=0). IF holds the same payload, which is re-decoded next cycle. Register file reads then see fresh data.
- Flush: Ex_IsBranchTaken=1 causes Of_Valid<=0 and forces Of_Stall=0, even if a hazard is present.
- Priority: Rst > flush > stall > normal load.
- Non-valid input: If_Valid=0 causes Of_Valid<=0 and never stalls.
- Reset values: Of_Valid=0 and all other Of_* outputs 0. Of_Stall is 0 during Rst. Rst asserted mid-stall clears the bubble state; the next cycle is normal.
- Of_* data fields are don't-care when Of_Valid=0, but must be held unchanged during a bubble to reduce toggling.

Optional Feature:
Macro OF_WB_BYPASS_EN.
- Defined: write-through bypass. When Wb_WrEn is high and Wb_Rd equals a read address in the same cycle, that port returns Wb_Data.
- Undefined: the port returns the pre-write register value. The compiler guarantees a 3-instruction WB distance. Hazard logic is unchanged.

Test Plan:
- Reset, then WB writes r1=5 and r2=7, then "add r3,r1,r2" (I=0) -> next cycle Of_Valid=1, Of_Op1=5, Of_Op2=7, Of_Rd=3, Of_WrEn=1.
- "mov r4,#0xFFFF" for each modifier -> Of_Op2 = 0xFFFFFFFF (00), 0x0000FFFF (01), 0xFFFF0000 (10).
- "ld r5,[r1]" followed by "add r6,r5,r2" -> Of_Stall=1 for exactly one cycle and a bubble (Of_Valid=0). The add then issues with Of_Valid=1.
- Stall coinciding with Ex_IsBranchTaken=1 -> Of_Stall=0 and Of_Valid=0 next cycle.
- "call" at PC=0x100 with offset field 0x10 -> Of_BranchTarget=0x140, Of_Rd=15, Of_WrEn=1. Offset 0x7FFFFFF -> target 0xFC.
- Wb write r7=0xA5 in the same cycle that "st r7,[r1]" is read -> Of_StoreData=0xA5 with OF_WB_BYPASS_EN defined, and the old value (0) without it.

Source files
------------

// File: rtl/of_stage.sv
// Operand Fetch stage: decode, 16x32 register file, immediates, branch target, load-use stall.
// Optional build macro OF_WB_BYPASS_EN enables write-through of the WB port into both read ports.
module of_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 16,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      If_Valid,
    input  logic [DATA_WIDTH-1:0]     If_Pc,
    input  logic [31:0]               If_Instr,
    output logic                      Of_Stall,
    input  logic                      Ex_IsBranchTaken,
    input  logic                      Wb_WrEn,
    input  logic [REG_ADDR_WIDTH-1:0] Wb_Rd,
    input  logic [DATA_WIDTH-1:0]     Wb_Data,
    output logic                      Of_Valid,
    output logic [DATA_WIDTH-1:0]     Of_Pc,
    output logic [4:0]                Of_Opcode,
    output logic [DATA_WIDTH-1:0]     Of_Op1,
    output logic [DATA_WIDTH-1:0]     Of_Op2,
    output logic [DATA_WIDTH-1:0]     Of_StoreData,
    output logic [REG_ADDR_WIDTH-1:0] Of_Rd,
    output logic                      Of_WrEn,
    output logic                      Of_IsLoad,
    output logic                      Of_IsStore,
    output logic                      Of_IsBranch,
    output logic [DATA_WIDTH-1:0]     Of_BranchTarget
);

    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    localparam logic [REG_ADDR_WIDTH-1:0] RA_REG = REG_ADDR_WIDTH'(NUM_REGS - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     pc;
        logic [4:0]                opcode;
        logic [DATA_WIDTH-1:0]     op1;
        logic [DATA_WIDTH-1:0]     op2;
        logic [DATA_WIDTH-1:0]     store_data;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      wr_en;
        logic                      is_load;
        logic                      is_store;
        logic                      is_branch;
        logic [DATA_WIDTH-1:0]     branch_target;
    } of_payload_t;

    logic [4:0]                opcode;
    logic                      i_bit;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [1:0]                modifier;
    logic [15:0]               imm;

    assign opcode   = If_Instr[31:27];
    assign i_bit    = If_Instr[26];
    assign rd       = If_Instr[25:22];
    assign rs1      = If_Instr[21:18];
    assign rs2      = If_Instr[17:14];
    assign modifier = If_Instr[17:16];
    assign imm      = If_Instr[15:0];

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic [REG_ADDR_WIDTH-1:0] rd_addr_a;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_b;
    logic [DATA_WIDTH-1:0]     rd_data_a;
    logic [DATA_WIDTH-1:0]     rd_data_b;

    assign rd_addr_a = (opcode == OP_RET) ? RA_REG : rs1;
    assign rd_addr_b = (opcode == OP_ST) ? rd : rs2;

`ifdef OF_WB_BYPASS_EN
    assign rd_data_a = (Wb_WrEn && (Wb_Rd == rd_addr_a)) ? Wb_Data : regs_q[rd_addr_a];
    assign rd_data_b = (Wb_WrEn && (Wb_Rd == rd_addr_b)) ? Wb_Data : regs_q[rd_addr_b];
`else
    assign rd_data_a = regs_q[rd_addr_a];
    assign rd_data_b = regs_q[rd_addr_b];
`endif

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (Wb_WrEn) begin
            regs_d[Wb_Rd] = Wb_Data;
        end
    end

    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] br_offset;
    of_payload_t           decoded;

    always_comb begin
        case (modifier)
            2'b01:   imm_ext = DATA_WIDTH'(imm);
            2'b10:   imm_ext = DATA_WIDTH'({imm, 16'h0000});
            default: imm_ext = {{(DATA_WIDTH-16){imm[15]}}, imm};
        endcase
        br_offset = {{(DATA_WIDTH-27){If_Instr[26]}}, If_Instr[26:0]};

        decoded               = '0;
        decoded.pc            = If_Pc;
        decoded.opcode        = opcode;
        decoded.op1           = rd_data_a;
        decoded.op2           = i_bit ? imm_ext : rd_data_b;
        decoded.store_data    = rd_data_b;
        decoded.rd            = (opcode == OP_CALL) ? RA_REG : rd;
        decoded.wr_en         = (opcode <= OP_ASR && opcode != OP_CMP) ||
                                (opcode == OP_LD) || (opcode == OP_CALL);
        decoded.is_load       = (opcode == OP_LD);
        decoded.is_store      = (opcode == OP_ST);
        decoded.is_branch     = (opcode >= OP_BEQ) && (opcode <= OP_RET);
        decoded.branch_target = If_Pc + (br_offset << 2);
    end

    logic        of_valid_q;
    logic        of_valid_d;
    of_payload_t payload_q;
    of_payload_t payload_d;

    // Source-register usage of the incoming instruction, compared against the load in EX.
    logic uses_rs1;
    logic uses_rs2;
    logic uses_rd;
    logic uses_ra;
    logic hazard;

    assign uses_rs1 = !((opcode == OP_MOV) || (opcode == OP_B) || (opcode == OP_CALL));
    assign uses_rs2 = !i_bit && (opcode <= OP_ASR);
    assign uses_rd  = (opcode == OP_ST);
    assign uses_ra  = (opcode == OP_RET);

    assign hazard = of_valid_q && payload_q.is_load && If_Valid &&
                    ((uses_rs1 && (rs1 == payload_q.rd)) ||
                     (uses_rs2 && (rs2 == payload_q.rd)) ||
                     (uses_rd  && (rd  == payload_q.rd)) ||
                     (uses_ra  && (RA_REG == payload_q.rd)));

    assign Of_Stall = hazard && !Ex_IsBranchTaken && !Rst;

    // Data fields only move on an accepted instruction so bubbles do not toggle them.
    always_comb begin
        of_valid_d = 1'b0;
        payload_d  = payload_q;
        if (!Ex_IsBranchTaken && !hazard && If_Valid) begin
            of_valid_d = 1'b1;
            payload_d  = decoded;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            of_valid_q <= 1'b0;
            payload_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            of_valid_q <= of_valid_d;
            payload_q  <= payload_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign Of_Valid        = of_valid_q;
    assign Of_Pc           = payload_q.pc;
    assign Of_Opcode       = payload_q.opcode;
    assign Of_Op1          = payload_q.op1;
    assign Of_Op2          = payload_q.op2;
    assign Of_StoreData    = payload_q.store_data;
    assign Of_Rd           = payload_q.rd;
    assign Of_WrEn         = payload_q.wr_en;
    assign Of_IsLoad       = payload_q.is_load;
    assign Of_IsStore      = payload_q.is_store;
    assign Of_IsBranch     = payload_q.is_branch;
    assign Of_BranchTarget = payload_q.branch_target;

endmodule

// File: tb/tb_of_stage.sv
// Bench for of_stage: directed steps then random traffic against an ISA-level reference model.
module tb_of_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        If_Valid;
    logic [31:0] If_Pc;
    logic [31:0] If_Instr;
    logic        Of_Stall;
    logic        Ex_IsBranchTaken;
    logic        Wb_WrEn;
    logic [3:0]  Wb_Rd;
    logic [31:0] Wb_Data;
    logic        Of_Valid;
    logic [31:0] Of_Pc;
    logic [4:0]  Of_Opcode;
    logic [31:0] Of_Op1;
    logic [31:0] Of_Op2;
    logic [31:0] Of_StoreData;
    logic [3:0]  Of_Rd;
    logic        Of_WrEn;
    logic        Of_IsLoad;
    logic        Of_IsStore;
    logic        Of_IsBranch;
    logic [31:0] Of_BranchTarget;

    always #5 Clk = ~Clk;

    of_stage dut (
        .Clk(Clk), .Rst(Rst), .If_Valid(If_Valid), .If_Pc(If_Pc), .If_Instr(If_Instr),
        .Of_Stall(Of_Stall), .Ex_IsBranchTaken(Ex_IsBranchTaken),
        .Wb_WrEn(Wb_WrEn), .Wb_Rd(Wb_Rd), .Wb_Data(Wb_Data),
        .Of_Valid(Of_Valid), .Of_Pc(Of_Pc), .Of_Opcode(Of_Opcode), .Of_Op1(Of_Op1),
        .Of_Op2(Of_Op2), .Of_StoreData(Of_StoreData), .Of_Rd(Of_Rd), .Of_WrEn(Of_WrEn),
        .Of_IsLoad(Of_IsLoad), .Of_IsStore(Of_IsStore), .Of_IsBranch(Of_IsBranch),
        .Of_BranchTarget(Of_BranchTarget)
    );

    int errs   = 0;
    int checks = 0;

    logic [31:0] m_regs [16];
    logic        m_valid;
    logic [31:0] m_pc, m_op1, m_op2, m_sd, m_bt;
    logic [4:0]  m_opcode;
    logic [3:0]  m_rd;
    logic        m_wren, m_isload, m_isstore, m_isbr;
    logic        exp_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic i, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [17:0] lo);
        return {op, i, rd, rs1, lo};
    endfunction

    // Registers the instruction consumes as sources, as a one-hot set.
    function automatic logic [15:0] src_set(input logic [31:0] ins);
        logic [4:0]  op;
        logic [15:0] s;
        op = ins[31:27];
        s  = '0;
        if (!(op inside {5'd9, 5'd18, 5'd19})) s[ins[21:18]] = 1'b1;
        if (!ins[26] && op <= 5'd12)           s[ins[17:14]] = 1'b1;
        if (op == 5'd15)                       s[ins[25:22]] = 1'b1;
        if (op == 5'd20)                       s[15]         = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] rv(input logic [3:0] a);
`ifdef OF_WB_BYPASS_EN
        if (Wb_WrEn && Wb_Rd == a) return Wb_Data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic model_hazard();
        logic [15:0] s;
        s = src_set(If_Instr);
        return m_valid && m_isload && If_Valid && s[m_rd];
    endfunction

    task automatic model_clock(input logic hz);
        logic [4:0]  op;
        logic [15:0] imm;
        logic [31:0] immv, sx;
        if (Rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
            m_valid = 0; m_pc = 0; m_opcode = 0; m_op1 = 0; m_op2 = 0; m_sd = 0;
            m_rd = 0; m_wren = 0; m_isload = 0; m_isstore = 0; m_isbr = 0; m_bt = 0;
            return;
        end
        if (!Ex_IsBranchTaken && !hz && If_Valid) begin
            op  = If_Instr[31:27];
            imm = If_Instr[15:0];
            case (If_Instr[17:16])
                2'd1:    immv = {16'h0000, imm};
                2'd2:    immv = {imm, 16'h0000};
                default: immv = 32'($signed(imm));
            endcase
            sx        = 32'($signed(If_Instr[26:0]));
            m_valid   = 1;
            m_pc      = If_Pc;
            m_opcode  = op;
            m_op1     = rv(op == 5'd20 ? 4'd15 : If_Instr[21:18]);
            m_sd      = rv(op == 5'd15 ? If_Instr[25:22] : If_Instr[17:14]);
            m_op2     = If_Instr[26] ? immv : m_sd;
            m_rd      = (op == 5'd19) ? 4'd15 : If_Instr[25:22];
            m_wren    = op inside {[5'd0:5'd4], [5'd6:5'd12], 5'd14, 5'd19};
            m_isload  = (op == 5'd14);
            m_isstore = (op == 5'd15);
            m_isbr    = op inside {[5'd16:5'd20]};
            m_bt      = If_Pc + sx * 4;
        end else begin
            m_valid = 0;
        end
        if (Wb_WrEn) m_regs[Wb_Rd] = Wb_Data;
    endtask

    task automatic cycle();
        #1;
        exp_stall = model_hazard() && !Ex_IsBranchTaken && !Rst;
        chk("stall", 32'(Of_Stall), 32'(exp_stall));
        @(posedge Clk);
        model_clock(model_hazard());
        #1;
        chk("valid", 32'(Of_Valid), 32'(m_valid));
        chk("pc", Of_Pc, m_pc);
        chk("opcode", 32'(Of_Opcode), 32'(m_opcode));
        chk("op1", Of_Op1, m_op1);
        chk("op2", Of_Op2, m_op2);
        chk("store_data", Of_StoreData, m_sd);
        chk("rd", 32'(Of_Rd), 32'(m_rd));
        chk("wren", 32'(Of_WrEn), 32'(m_wren));
        chk("is_load", 32'(Of_IsLoad), 32'(m_isload));
        chk("is_store", 32'(Of_IsStore), 32'(m_isstore));
        chk("is_branch", 32'(Of_IsBranch), 32'(m_isbr));
        chk("branch_target", Of_BranchTarget, m_bt);
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic fl, input logic we, input logic [3:0] wr, input logic [31:0] wd);
        If_Valid = v; If_Pc = pc; If_Instr = ins; Ex_IsBranchTaken = fl;
        Wb_WrEn = we; Wb_Rd = wr; Wb_Data = wd;
        cycle();
    endtask

    initial begin
        logic [31:0] exp_mov [4];
        logic [31:0] ld_r5, add_r6, ins, r32, pc;
        logic [4:0]  op;
        exp_mov = '{32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFF};
        ld_r5   = mk(5'd14, 1'b1, 4'd5, 4'd1, 18'd0);
        add_r6  = mk(5'd0, 1'b0, 4'd6, 4'd5, {4'd2, 14'd0});
        for (int i = 0; i < 16; i++) m_regs[i] = 'x;
        m_valid = 'x;

        Rst = 1;
        step(1, 32'h40, ld_r5, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("reset_valid", 32'(Of_Valid), 0);
        chk("reset_target", Of_BranchTarget, 0);
        Rst = 0;

        step(0, 0, 0, 0, 1, 4'd1, 32'd5);
        step(0, 0, 0, 0, 1, 4'd2, 32'd7);
        step(1, 32'h10, mk(5'd0, 1'b0, 4'd3, 4'd1, {4'd2, 14'd0}), 0, 0, 0, 0);
        chk("add_valid", 32'(Of_Valid), 1);
        chk("add_op1", Of_Op1, 32'd5);
        chk("add_op2", Of_Op2, 32'd7);
        chk("add_rd", 32'(Of_Rd), 3);

        for (int m = 0; m < 4; m++) begin
            step(1, 32'h14, mk(5'd9, 1'b1, 4'd4, 4'd0, {2'(m), 16'hFFFF}), 0, 0, 0, 0);
            chk("mov_imm", Of_Op2, exp_mov[m]);
        end

        step(1, 32'h20, ld_r5, 0, 0, 0, 0);
        step(1, 32'h24, add_r6, 0, 0, 0, 0);
        chk("ld_use_bubble", 32'(Of_Valid), 0);
        step(1, 32'h24, add_r6, 0, 0, 0, 0);
        chk("ld_use_issue", 32'(Of_Valid), 1);

        step(1, 32'h30, ld_r5, 0, 0, 0, 0);
        step(1, 32'h34, add_r6, 1, 0, 0, 0);
        chk("flush_over_stall", 32'(Of_Valid), 0);

        step(1, 32'h100, {5'd19, 27'h10}, 0, 0, 0, 0);
        chk("call_target", Of_BranchTarget, 32'h140);
        chk("call_rd", 32'(Of_Rd), 15);
        step(1, 32'h100, {5'd19, 27'h7FFFFFF}, 0, 0, 0, 0);
        chk("call_neg_target", Of_BranchTarget, 32'hFC);

        step(1, 32'h200, mk(5'd15, 1'b1, 4'd7, 4'd1, 18'd0), 0, 1, 4'd7, 32'hA5);
`ifdef OF_WB_BYPASS_EN
        chk("st_same_cycle_wb", Of_StoreData, 32'hA5);
`else
        chk("st_same_cycle_wb", Of_StoreData, 32'h0);
`endif

        step(1, 32'h50, ld_r5, 0, 0, 0, 0);
        Rst = 1;
        step(1, 32'h54, add_r6, 0, 0, 0, 0);
        Rst = 0;
        step(1, 32'h54, add_r6, 0, 0, 0, 0);
        chk("post_reset_issue", 32'(Of_Valid), 1);

        ins = 0;
        pc  = 0;
        for (int n = 0; n < 500; n++) begin
            Rst = ($urandom_range(0, 59) == 0);
            if (!exp_stall) begin
                op  = ($urandom_range(0, 9) < 3) ? 5'd14 : 5'($urandom_range(0, 31));
                r32 = $urandom();
                ins = {op, r32[26:0]};
                if ($urandom_range(0, 1) == 1) ins = ins & 32'hFCCCFFFF;
                pc  = $urandom() & 32'hFFFFFFFC;
            end
            step(exp_stall || ($urandom_range(0, 3) != 0), pc, ins,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1),
                 4'($urandom_range(0, 15)), $urandom());
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
